// File: rtl/regfile_dump_pkg.sv
// Shared types and defaults for the register-file dump engine.
package regfile_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_SEND = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    localparam logic [7:0]  HDR_BYTE  = 8'hA5;
    localparam int unsigned DEF_NREGS = 32;
    localparam int unsigned DEF_AW    = 5;
    localparam int unsigned DEF_DW    = 32;

endpackage

// File: rtl/regfile_dump.sv
// Streams x0..NREGS-1 as a framed byte stream: header, little-endian words, XOR checksum.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int unsigned NREGS = DEF_NREGS,
    parameter int unsigned AW    = DEF_AW,
    parameter int unsigned DW    = DEF_DW,
    parameter logic [7:0]  HDR   = HDR_BYTE
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rf_addr,
    input  logic [DW-1:0] rf_data,
    output logic [7:0]    tx_byte,
    output logic          tx_valid,
    input  logic          tx_ready
);

    localparam int unsigned NB = DW / 8;
    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_idx;
    logic [BW-1:0] r_byte_cnt;
    logic [7:0]    r_csum;
    logic [DW-1:0] r_shift;
    logic          r_done;
    logic          w_last_byte;
    logic          w_last_reg;

    assign w_last_byte = (r_byte_cnt == LAST_BYTE);
    assign w_last_reg  = (r_idx == LAST_IDX);

    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign rf_addr = r_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // tx_valid/tx_byte decode from state only; tx_ready only steers the next state.
    always_comb begin
        w_state_nxt = r_state;
        tx_valid    = 1'b0;
        tx_byte     = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                tx_valid = 1'b1;
                tx_byte  = HDR;
                if (tx_ready) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_byte  = r_shift[7:0];
                if (tx_ready && w_last_byte) begin
                    w_state_nxt = w_last_reg ? ST_CSUM : ST_LOAD;
                end
            end
            ST_CSUM: begin
                tx_valid = 1'b1;
                tx_byte  = r_csum;
                if (tx_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_byte_cnt <= '0;
            r_csum     <= '0;
            r_shift    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == ST_CSUM) && tx_ready;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx      <= '0;
                        r_byte_cnt <= '0;
                        r_csum     <= '0;
                    end
                end
                ST_LOAD: begin
                    r_shift    <= rf_data;
                    r_byte_cnt <= '0;
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        r_csum     <= r_csum ^ r_shift[7:0];
                        r_shift    <= r_shift >> 8;
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        if (w_last_byte && !w_last_reg) begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: a register-file model feeds the DUT, a byte sink checks the stream.
module tb_regfile_dump;

    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic          tx_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          tx_valid;
    logic [7:0]    tx_byte;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;

    logic [DW-1:0] rf [NREGS];
    logic [7:0]    sb [$];
    logic [7:0]    last_byte = '0;
    int            n_checks  = 0;
    int            n_pass    = 0;
    int            rx_count  = 0;
    int            rdy_mode  = 0;

    assign rf_data = rf[rf_addr];

    always #5 clk = ~clk;

    regfile_dump #(
        .NREGS(NREGS),
        .AW   (AW),
        .DW   (DW),
        .HDR  (8'hA5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .rf_addr (rf_addr),
        .rf_data (rf_data),
        .tx_byte (tx_byte),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    // Expected frame from the current register-file contents.
    function automatic void push_frame();
        logic [7:0] b;
        logic [7:0] cs;
        cs = '0;
        sb.push_back(8'hA5);
        for (int r = 0; r < NREGS; r++) begin
            for (int k = 0; k < DW / 8; k++) begin
                b = rf[r][8*k +: 8];
                sb.push_back(b);
                cs ^= b;
            end
        end
        sb.push_back(cs);
    endfunction

    // Byte sink: ready chosen at negedge, transfer happens at the following posedge.
    initial begin : sink
        logic       prev_stall;
        logic [7:0] prev_byte;
        logic [7:0] exp_b;
        prev_stall = 1'b0;
        prev_byte  = '0;
        forever begin
            @(negedge clk);
            tx_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    n_checks++;
                    if (tx_valid !== 1'b1 || tx_byte !== prev_byte)
                        $display("FAIL stall_hold: got valid=%b byte=%h want valid=1 byte=%h",
                                 tx_valid, tx_byte, prev_byte);
                    else
                        n_pass++;
                end
                if (tx_valid === 1'b1 && tx_ready) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        $display("FAIL stream_extra: got byte %h with no byte expected", tx_byte);
                    end else begin
                        exp_b = sb.pop_front();
                        if (tx_byte !== exp_b)
                            $display("FAIL stream_byte[%0d]: got %h want %h", rx_count, tx_byte, exp_b);
                        else
                            n_pass++;
                    end
                    rx_count++;
                    last_byte = tx_byte;
                end
                prev_stall = (tx_valid === 1'b1) && !tx_ready;
                prev_byte  = tx_byte;
            end
        end
    end

    task automatic start_pulse();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns the cycle (1 = first cycle after start is sampled) in which done is seen, or -1.
    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (done === 1'b1) return;
        end
        cycles = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++;
        if (tx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", tx_valid); else n_pass++;
        n_checks++;
        if (tx_byte !== 8'h00) $display("FAIL reset_byte: got %h want 00", tx_byte); else n_pass++;
        n_checks++;
        if (rf_addr !== 5'd0) $display("FAIL reset_addr: got %0d want 0", rf_addr); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_all_zero();
        int busy_cnt;
        int done_at;
        logic busy_at_done;
        for (int r = 0; r < NREGS; r++) rf[r] = '0;
        rdy_mode = 0;
        rx_count = 0;
        push_frame();
        start_pulse();
        busy_cnt     = 0;
        done_at      = -1;
        busy_at_done = 1'b1;
        for (int n = 1; n <= 400 && done_at < 0; n++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_at      = n;
                busy_at_done = busy;
            end
        end
        n_checks++;
        if (done_at != 163) $display("FAIL zero_done_cycle: got %0d want 163", done_at); else n_pass++;
        n_checks++;
        if (busy_cnt != 162) $display("FAIL zero_busy_cycles: got %0d want 162", busy_cnt); else n_pass++;
        n_checks++;
        if (busy_at_done !== 1'b0) $display("FAIL zero_busy_at_done: got %b want 0", busy_at_done); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) $display("FAIL zero_done_pulse: got %b want 0", done); else n_pass++;
        n_checks++;
        if (rx_count != 130) $display("FAIL zero_count: got %0d want 130", rx_count); else n_pass++;
        n_checks++;
        if (sb.size() != 0) $display("FAIL zero_left: got %0d want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_x5_pattern();
        int cyc;
        for (int r = 0; r < NREGS; r++) rf[r] = '0;
        rf[5] = 32'hDEAD_BEEF;
        rdy_mode = 0;
        rx_count = 0;
        push_frame();
        start_pulse();
        wait_done(400, cyc);
        n_checks++;
        if (cyc < 0) $display("FAIL x5_timeout: got no done want done"); else n_pass++;
        n_checks++;
        if (last_byte !== 8'h22) $display("FAIL x5_csum: got %h want 22", last_byte); else n_pass++;
        n_checks++;
        if (sb.size() != 0) $display("FAIL x5_left: got %0d want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_random_ready();
        int cyc;
        for (int r = 0; r < NREGS; r++) rf[r] = DW'(r);
        rdy_mode = 1;
        rx_count = 0;
        push_frame();
        start_pulse();
        wait_done(2000, cyc);
        rdy_mode = 0;
        n_checks++;
        if (cyc < 0) $display("FAIL rand_timeout: got no done want done"); else n_pass++;
        n_checks++;
        if (rx_count != 130) $display("FAIL rand_count: got %0d want 130", rx_count); else n_pass++;
        n_checks++;
        if (last_byte !== 8'h00) $display("FAIL rand_csum: got %h want 00", last_byte); else n_pass++;
        n_checks++;
        if (sb.size() != 0) $display("FAIL rand_left: got %0d want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_snapshot();
        int cyc;
        int waited;
        for (int r = 0; r < NREGS; r++) rf[r] = DW'(r);
        rdy_mode = 1;
        rx_count = 0;
        push_frame();
        start_pulse();
        waited = 0;
        while (rx_count < 14 && waited < 1000) begin
            @(posedge clk);
            waited++;
        end
        n_checks++;
        if (rx_count < 14) $display("FAIL snap_wait: got %0d bytes want 14", rx_count); else n_pass++;
        @(negedge clk);
        rf[3] = 32'h0000_0011;
        wait_done(2000, cyc);
        n_checks++;
        if (cyc < 0 || last_byte !== 8'h00)
            $display("FAIL snap_first_csum: got %h (cyc %0d) want 00", last_byte, cyc);
        else
            n_pass++;
        rx_count = 0;
        push_frame();
        start_pulse();
        wait_done(2000, cyc);
        rdy_mode = 0;
        n_checks++;
        if (cyc < 0 || last_byte !== 8'h12)
            $display("FAIL snap_second_csum: got %h (cyc %0d) want 12", last_byte, cyc);
        else
            n_pass++;
        n_checks++;
        if (rx_count != 130 || sb.size() != 0)
            $display("FAIL snap_count: got %0d/%0d want 130/0", rx_count, sb.size());
        else
            n_pass++;
    endtask

    task automatic test_start_ignore();
        int cyc;
        for (int r = 0; r < NREGS; r++) rf[r] = '0;
        rf[7] = 32'h0102_0304;
        rdy_mode = 0;
        rx_count = 0;
        push_frame();
        start_pulse();
        for (int k = 2; k <= 163; k++) begin
            @(posedge clk);
            #1;
            if (k == 163) begin
                n_checks++;
                if (done !== 1'b1 || busy !== 1'b0)
                    $display("FAIL ign_done: got done=%b busy=%b want done=1 busy=0", done, busy);
                else
                    n_pass++;
            end
            start = (k == 5 || k == 50 || k == 100 || k == 162);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL ign_csum_start: got busy=%b want 0", busy); else n_pass++;
        n_checks++;
        if (rx_count != 130 || sb.size() != 0)
            $display("FAIL ign_first_count: got %0d/%0d want 130/0", rx_count, sb.size());
        else
            n_pass++;
        rx_count = 0;
        push_frame();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(400, cyc);
        n_checks++;
        if (cyc < 0 || rx_count != 130 || sb.size() != 0)
            $display("FAIL ign_second_frame: got cyc=%0d count=%0d left=%0d want 130 bytes",
                     cyc, rx_count, sb.size());
        else
            n_pass++;
    endtask

    task automatic test_reset_midframe();
        int cyc;
        int waited;
        logic saw_done;
        for (int r = 0; r < NREGS; r++) rf[r] = DW'(r);
        rdy_mode = 0;
        rx_count = 0;
        push_frame();
        start_pulse();
        waited = 0;
        while (rx_count < 42 && waited < 400) begin
            @(posedge clk);
            waited++;
        end
        #1 rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        n_checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL rst_mid_state: got valid=%b busy=%b want 0/0", tx_valid, busy);
        else
            n_pass++;
        saw_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) $display("FAIL rst_mid_done: got done pulse want none"); else n_pass++;
        rx_count = 0;
        push_frame();
        start_pulse();
        wait_done(400, cyc);
        n_checks++;
        if (cyc < 0 || rx_count != 130 || sb.size() != 0 || last_byte !== 8'h00)
            $display("FAIL rst_mid_refresh: got cyc=%0d count=%0d left=%0d csum=%h want 130 bytes csum 00",
                     cyc, rx_count, sb.size(), last_byte);
        else
            n_pass++;
    endtask

    initial begin
        for (int r = 0; r < NREGS; r++) rf[r] = '0;
        test_reset();
        test_all_zero();
        test_x5_pattern();
        test_random_ready();
        test_snapshot();
        test_start_ignore();
        test_reset_midframe();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine for the single-cycle core's 32×32 register file. On a start pulse it walks x0..x31 through a dedicated asynchronous read port and streams the contents as bytes over a valid/ready interface, framed by a header byte and closed by an XOR checksum. It sits beside the register file, on the reader side of its write port, and typically feeds the board's UART transmitter or a testbench byte sink.

## Interface

Parameters:
- NREGS, 32, registers dumped (x0..NREGS-1)
- AW, 5, register address width
- DW, 32, register width (multiple of 8)
- HDR, 8'hA5, frame header byte

Ports:
- clk  in  1  core clock; all state updates on posedge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  dump request, sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until the checksum is accepted
- done  out  1  single-cycle pulse after the checksum byte is accepted
- rf_addr  out  AW  read address to the register file's auxiliary read port
- rf_data  in  DW  combinational read data for rf_addr
- tx_byte  out  8  stream byte
- tx_valid  out  1  tx_byte valid
- tx_ready  in  1  sink accepts; a transfer occurs when tx_valid && tx_ready at posedge

## Operation

- Frame: HDR, then for r = 0..NREGS-1 the DW/8 bytes of x[r], little-endian, then CSUM = XOR of all data bytes (header excluded). NREGS=32 gives 130 bytes; stream index of byte k of x[r] is 1+4r+k.
- States:
  - IDLE: busy=0, tx_valid=0. start=1 → HDR; clear idx, byte_cnt, csum.
  - HDR: tx_valid=1, tx_byte=HDR. Transfer → LOAD.
  - LOAD: tx_valid=0; rf_addr=idx; shift ← rf_data; byte_cnt ← 0 → SEND. One cycle, unconditional.
  - SEND: tx_valid=1, tx_byte=shift[7:0]. On transfer: csum ^= byte; shift >>= 8; byte_cnt++. At the last byte: idx==NREGS-1 → CSUM, else idx++ → LOAD.
  - CSUM: tx_valid=1, tx_byte=csum. Transfer → IDLE, done=1 next cycle.
- rf_addr = idx at all times; only the LOAD-cycle value matters. Each word is snapshotted at its LOAD posedge; core writes (negedge) to a register after its LOAD are not reflected. x0 is dumped as read (0).
- Handshake: once tx_valid is high, tx_byte stays stable and tx_valid stays high until the transfer. No bubble except the LOAD cycle.
- start while busy is ignored (no queueing). start in the same cycle as the final CSUM transfer is ignored; it is honored from IDLE onward.
- Reset anywhere: state IDLE, idx=0, byte_cnt=0, csum=0, shift=0; the partial frame is abandoned, no done.

## Timing

- Reset values: busy=0, done=0, tx_valid=0, tx_byte=0, rf_addr=0.
- start sampled at edge t → HDR valid from t+1.
- With tx_ready tied high: 1 + NREGS·(1 + DW/8) + 1 = 162 cycles in HDR..CSUM; busy high for those 162 cycles; done high in the cycle immediately after, with busy already low.
- tx_ready low adds exactly one cycle per stalled cycle; no data loss or duplication.
- Outputs are Moore decodes of registered state; no combinational path from tx_ready to tx_valid/tx_byte.

## Structure

- Shared package: state enum (IDLE, HDR, LOAD, SEND, CSUM), HDR constant, default NREGS/AW/DW.
- Single module; no sub-module. The register file gains a third read port (rf_addr/rf_data) in the integrating top, with no change to its write behaviour.

## Test plan

- All registers zero, tx_ready=1, pulse start → bytes A5, 128×00, 00; done at cycle 163 after start; busy high for exactly 162 cycles.
- x5=DEADBEEF, others 0 → bytes 21..24 = EF BE AD DE; checksum 22.
- x[r]=r for all r, random tx_ready (≈50%) → byte 1+4r = r, other data bytes 00; checksum 00; tx_byte stable while valid&&!ready; 130 transfers total.
- Core writes x3=0x11 at a negedge after x3's LOAD and before the x4 LOAD → x3's old value streamed; the new value appears only in the next dump.
- start repeated during busy and during the final CSUM transfer → exactly one frame; a start one cycle after done yields a second complete frame.
- rst_n low for one cycle mid-SEND of x10 → next cycle tx_valid=0, busy=0, no done; a fresh start yields a full, correct 130-byte frame.
